// File: rtl/miriscv_mem_pkg.sv
// Shared definitions for the two-requester memory arbiter:
// FSM state encoding, requester indices and RISC-V funct3 access sizes.
package miriscv_mem_pkg;

    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned STATE_W = 2;

    // Arbiter FSM states
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Requester indices (also the value of the owner/winner bit)
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    // funct3 access size encodings
    localparam logic [SIZE_W-1:0] SIZE_SB  = 3'b000;
    localparam logic [SIZE_W-1:0] SIZE_SH  = 3'b001;
    localparam logic [SIZE_W-1:0] SIZE_SW  = 3'b010;
    localparam logic [SIZE_W-1:0] SIZE_LBU = 3'b100;
    localparam logic [SIZE_W-1:0] SIZE_LHU = 3'b101;

    // Index of the requester that is not idx
    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Winner select for the core/dma arbiter.
// Build option: MEM_ARB_RR_EN -- when defined, ties are resolved round-robin
// with a one-bit pointer that moves only on a grant; when undefined, core
// always wins a tie and no pointer register exists.
// Ports:
//   clk_i, reset        clock and asynchronous active-high reset
//   core_req_i/dma_req_i raw requests
//   take_i              a grant is being issued this cycle
//   win_idx_c           combinational winner index (REQ_CORE/REQ_DMA)
//   any_req_c           combinational "some request is pending"
module arb_picker
    import miriscv_mem_pkg::*;
(
    input  logic clk_i,
    input  logic reset,
    input  logic core_req_i,
    input  logic dma_req_i,
    input  logic take_i,
    output logic win_idx_c,
    output logic any_req_c
);

    assign any_req_c = core_req_i | dma_req_i;

`ifdef MEM_ARB_RR_EN
    // ptr_q holds the index that wins the next tie
    logic ptr_q;
    logic ptr_d;

    // Winner select and pointer update
    always_comb begin
        win_idx_c = REQ_CORE;
        ptr_d     = ptr_q;
        if (core_req_i && dma_req_i) begin
            win_idx_c = ptr_q;
        end else if (dma_req_i) begin
            win_idx_c = REQ_DMA;
        end
        // The requester not granted last wins next time
        if (take_i) begin
            ptr_d = other_req(win_idx_c);
        end
    end

    // Pointer register
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            ptr_q <= REQ_CORE;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: core first
    always_comb begin
        win_idx_c = REQ_CORE;
        if (!core_req_i && dma_req_i) begin
            win_idx_c = REQ_DMA;
        end
    end

    // Clock, reset and take are only needed by the round-robin pointer
    logic unused_inputs;
    assign unused_inputs = clk_i ^ reset ^ take_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (core, dma) memory arbiter with a single outstanding access.
// IDLE -> ACCESS -> RESP -> IDLE; a request sampled at edge N sees gnt and
// mem_req in cycle N+1 and rvalid in cycle N+3. Arbitration reopens in the
// IDLE cycle that carries rvalid, so back-to-back accesses are 3 cycles apart.
// Build option: MEM_ARB_RR_EN (round-robin tie break, inside arb_picker).
// Ports:
//   clk_i, reset                          clock, async active-high reset
//   core_*_i / dma_*_i                    req, we, size (funct3), addr, wd
//   core_gnt_o/rvalid_o/rd_o, dma_*       per-requester grant, completion, read data
//   mem_req_o/we_o/size_o/addr_o/wd_o     memory request (valid in ACCESS only)
//   mem_rd_i                              memory read data (valid in RESP only)
//   busy_o                                high whenever not IDLE
module mem_arbiter
    import miriscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset,

    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [SIZE_W-1:0] core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rd_o,

    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [SIZE_W-1:0] dma_size_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wd_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] dma_rd_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [SIZE_W-1:0] mem_size_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,

    output logic              busy_o
);

    arb_state_e state_q, state_d;

    // Latched transaction
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    // Registered outputs
    logic              core_gnt_q, core_gnt_d;
    logic              dma_gnt_q, dma_gnt_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0] core_rd_q, core_rd_d;
    logic [DATA_W-1:0] dma_rd_q, dma_rd_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;

    logic win_idx_c;
    logic any_req_c;
    logic take_c;

    // A grant is issued whenever IDLE sees any request
    assign take_c = (state_q == ST_IDLE) && any_req_c;

    arb_picker u_picker (
        .clk_i      (clk_i),
        .reset      (reset),
        .core_req_i (core_req_i),
        .dma_req_i  (dma_req_i),
        .take_i     (take_c),
        .win_idx_c  (win_idx_c),
        .any_req_c  (any_req_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wd_d          = wd_q;
        core_gnt_d    = 1'b0;
        dma_gnt_d     = 1'b0;
        core_rvalid_d = 1'b0;
        dma_rvalid_d  = 1'b0;
        core_rd_d     = core_rd_q;
        dma_rd_d      = dma_rd_q;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (take_c) begin
                    state_d = ST_ACCESS;
                    owner_d = win_idx_c;
                    if (win_idx_c == REQ_DMA) begin
                        we_d   = dma_we_i;
                        size_d = dma_size_i;
                        addr_d = dma_addr_i;
                        wd_d   = dma_wd_i;
                    end else begin
                        we_d   = core_we_i;
                        size_d = core_size_i;
                        addr_d = core_addr_i;
                        wd_d   = core_wd_i;
                    end
                    // Grant and memory strobes are registered, so they are
                    // set here to appear during ACCESS
                    mem_req_d  = 1'b1;
                    mem_we_d   = we_d;
                    core_gnt_d = (win_idx_c == REQ_CORE);
                    dma_gnt_d  = (win_idx_c == REQ_DMA);
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // Writes complete with rvalid but keep rd_o unchanged
                if (owner_q == REQ_DMA) begin
                    dma_rvalid_d = 1'b1;
                    if (!we_q) begin
                        dma_rd_d = mem_rd_i;
                    end
                end else begin
                    core_rvalid_d = 1'b1;
                    if (!we_q) begin
                        core_rd_d = mem_rd_i;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= REQ_CORE;
            we_q          <= 1'b0;
            size_q        <= '0;
            addr_q        <= '0;
            wd_q          <= '0;
            core_gnt_q    <= 1'b0;
            dma_gnt_q     <= 1'b0;
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
            core_rd_q     <= '0;
            dma_rd_q      <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            size_q        <= size_d;
            addr_q        <= addr_d;
            wd_q          <= wd_d;
            core_gnt_q    <= core_gnt_d;
            dma_gnt_q     <= dma_gnt_d;
            core_rvalid_q <= core_rvalid_d;
            dma_rvalid_q  <= dma_rvalid_d;
            core_rd_q     <= core_rd_d;
            dma_rd_q      <= dma_rd_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            busy_q        <= busy_d;
        end
    end

    assign core_gnt_o    = core_gnt_q;
    assign dma_gnt_o     = dma_gnt_q;
    assign core_rvalid_o = core_rvalid_q;
    assign dma_rvalid_o  = dma_rvalid_q;
    assign core_rd_o     = core_rd_q;
    assign dma_rd_o      = dma_rd_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_size_o    = size_q;
    assign mem_addr_o    = addr_q;
    assign mem_wd_o      = wd_q;
    assign busy_o        = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte address width on all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width on all ports.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 For each requester p in {core, dma}, the block SHALL have inputs p_req_i (1), p_we_i (1), p_size_i (3, RISC-V funct3 encoding), p_addr_i (ADDR_W) and p_wd_i (DATA_W).
REQ-006 For each requester p, the block SHALL have outputs p_gnt_o (1), p_rvalid_o (1) and p_rd_o (DATA_W).
REQ-007 The memory side SHALL have outputs mem_req_o (1), mem_we_o (1), mem_size_o (3), mem_addr_o (ADDR_W), mem_wd_o (DATA_W), and input mem_rd_i (DATA_W).
REQ-008 The block SHALL have output busy_o, 1 bit, high whenever the state is not IDLE.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-010 In IDLE with any request high at a clock edge, the block SHALL pick a winner, latch the winner's we/size/addr/wd and the owner index, and move to ACCESS.
REQ-011 In ACCESS, the block SHALL drive mem_req_o=1 and mem_* from the latched fields, and drive the owner's gnt_o=1; gnt SHALL be high for exactly one cycle.
REQ-012 ACCESS SHALL unconditionally go to RESP; mem_rd_i is valid during RESP only.
REQ-013 On the RESP-to-IDLE edge, the block SHALL register mem_rd_i into the owner's rd_o and pulse the owner's rvalid_o for one cycle; writes also get rvalid as a completion, with rd_o unchanged.
REQ-014 Latency SHALL be: request sampled at edge N, gnt and mem_req high in cycle N+1, rvalid high in cycle N+3; one access per 3 cycles at most.
REQ-015 Arbitration SHALL be allowed in the same IDLE cycle that rvalid is high, giving back-to-back accesses.
REQ-016 A requester SHALL hold req and its fields stable until gnt; a req dropped before being sampled is ignored with no side effects.
REQ-017 A req still high after rvalid SHALL be treated as a new request.
REQ-018 The non-owner's gnt_o and rvalid_o SHALL stay 0 for the whole transaction, and its rd_o SHALL hold its previous value.
REQ-019 Requests arriving while busy SHALL be neither lost nor granted until IDLE.
REQ-020 Outside ACCESS, mem_req_o and mem_we_o SHALL be 0.

Reset
REQ-021 Reset SHALL force IDLE, all gnt/rvalid/mem_req/mem_we/busy outputs to 0, rd_o and the latched fields to 0, and the RR pointer to "core wins next".
REQ-022 Reset asserted mid-transaction SHALL abort it with no rvalid; the first access after release SHALL follow REQ-014.

Configuration
REQ-023 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last wins, and the pointer updates only on grant.
REQ-024 With MEM_ARB_RR_EN undefined, core SHALL always win and there SHALL be no pointer register.
REQ-025 With only one requester active, both configurations SHALL behave identically.

Structure
REQ-026 Package miriscv_mem_pkg SHALL hold the FSM state encoding, requester index constants (REQ_CORE=0, REQ_DMA=1) and the funct3 size constants (SB/SH/SW/LBU/LHU).
REQ-027 Sub-module arb_picker SHALL be used for the combinational winner select plus the RR pointer, and SHALL be the only code under MEM_ARB_RR_EN.

Verification
REQ-028 Scenario: core read, addr 0x100, mem_rd_i=0xDEADBEEF in RESP -> core_gnt in cycle N+1, mem_addr_o=0x100, core_rvalid in N+3 with core_rd_o=0xDEADBEEF.
REQ-029 Scenario: core and dma both request with RR enabled, held continuously -> grant order core, dma, core, dma, with accesses 3 cycles apart.
REQ-030 Scenario: same stimulus with RR disabled -> core granted every access; dma granted only after core_req drops.
REQ-031 Scenario: dma write, addr 0x20, wd 0x12345678, size SW -> mem_we_o=1 for exactly one cycle with those values; dma_rvalid pulses; dma_rd_o unchanged.
REQ-032 Scenario: reset asserted during RESP -> all outputs 0 immediately (asynchronous), no rvalid; the next core request is granted at N+1.
REQ-033 Scenario: dma_req pulsed while busy and dropped before IDLE -> no dma grant, and mem_* shows no access.
